// File: rtl/uart_tx_wb.sv
// uart_tx_wb: Wishbone slave that queues bytes in a FIFO and sends them as 8N1 UART frames.
// Define UART_TX_PARITY_EN to add a parity bit (STATUS bit4: 0 even, 1 odd) for 8E1/8O1 frames.
module uart_tx_wb #(
  parameter int CLK_FREQ_MHZ = 12,
  parameter int BAUD_RATE    = 115200,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  input  logic [3:0]  i_wb_sel,
  output logic        o_wb_ack,
  output logic        o_wb_stall,
  output logic [31:0] o_wb_data,
  output logic        o_uart_tx,
  output logic        o_irq
);

  localparam int          AW          = $clog2(FIFO_DEPTH);
  localparam int          RESET_DIV_I = (CLK_FREQ_MHZ * 32'sd1000000) / BAUD_RATE;
  localparam logic [15:0] RESET_DIV   = RESET_DIV_I[15:0];
  localparam logic [AW:0] FULL_COUNT  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

`ifdef UART_TX_PARITY_EN
  function automatic logic parity8(input logic [7:0] b, input logic odd);
    return (^b) ^ odd;
  endfunction
`endif

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q;
  logic [15:0]   div_q;
  logic          ack_q;
  logic [31:0]   rdata_q, rdata_d;
  state_e        state_q;
  logic [15:0]   baud_cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          tx_q;
`ifdef UART_TX_PARITY_EN
  logic          par_odd_q;
  logic          par_bit_q;
`endif

  logic        wb_req, push_req, push_ok, stat_wr, div_wr;
  logic        full, empty, busy, pop, bit_end;
  logic [1:0]  reg_sel;
  logic [15:0] div_eff;
  logic [31:0] status;
  logic        unused_bits;

  assign reg_sel  = i_wb_addr[3:2];
  assign wb_req   = i_wb_cyc & i_wb_stb;
  assign push_req = wb_req & i_wb_we & (reg_sel == 2'd0) & i_wb_sel[0];
  assign stat_wr  = wb_req & i_wb_we & (reg_sel == 2'd1) & i_wb_sel[0];
  assign div_wr   = wb_req & i_wb_we & (reg_sel == 2'd2);
  assign full     = (count_q == FULL_COUNT);
  assign empty    = (count_q == '0);
  assign push_ok  = push_req & ~full;
  assign busy     = (state_q != S_IDLE);
  assign pop      = ~busy & ~empty;
  assign bit_end  = (baud_cnt_q == 16'd0);
  assign div_eff  = (div_q == 16'd0) ? 16'd1 : div_q;

  assign unused_bits = ^{i_wb_addr[31:4], i_wb_addr[1:0], i_wb_data[31:16], i_wb_sel[3:2]};

  assign o_wb_ack   = ack_q;
  assign o_wb_data  = rdata_q;
  assign o_wb_stall = 1'b0;
  assign o_uart_tx  = tx_q;
  assign o_irq      = (empty & ~busy) | ovf_q;

  // FIFO occupancy and register read mux
  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    status       = 32'd0;
    status[0]    = full;
    status[1]    = empty;
    status[2]    = busy;
    status[3]    = ovf_q;
    status[15:8] = 8'(count_q);
`ifdef UART_TX_PARITY_EN
    status[4]    = par_odd_q;
`endif

    rdata_d = 32'd0;
    if (wb_req && !i_wb_we) begin
      case (reg_sel)
        2'd1:    rdata_d = status;
        2'd2:    rdata_d = {16'd0, div_q};
        default: rdata_d = 32'd0;
      endcase
    end else begin
      rdata_d = 32'd0;
    end
  end

  // FIFO storage; contents need no reset because count gates every read
  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= i_wb_data[7:0];
    end
  end

  // Bus response, FIFO pointers and control registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ack_q    <= 1'b0;
      rdata_q  <= 32'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      div_q    <= RESET_DIV;
`ifdef UART_TX_PARITY_EN
      par_odd_q <= 1'b0;
`endif
    end else begin
      ack_q   <= wb_req;
      rdata_q <= rdata_d;
      count_q <= count_d;
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push_req && full) begin
        ovf_q <= 1'b1;
      end else if (stat_wr && i_wb_data[3]) begin
        ovf_q <= 1'b0;
      end
`ifdef UART_TX_PARITY_EN
      if (stat_wr) begin
        par_odd_q <= i_wb_data[4];
      end
`endif
      if (div_wr && i_wb_sel[0]) begin
        div_q[7:0] <= i_wb_data[7:0];
      end
      if (div_wr && i_wb_sel[1]) begin
        div_q[15:8] <= i_wb_data[15:8];
      end
    end
  end

  // Serialiser: the stop bit's final cycle is spent in IDLE so back-to-back frames abut
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= 16'd0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'd0;
      tx_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_bit_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!empty) begin
            shift_q    <= mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
            par_bit_q  <= parity8(mem_q[rd_ptr_q], par_odd_q);
`endif
            tx_q       <= 1'b0;
            baud_cnt_q <= div_eff - 16'd1;
            state_q    <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            tx_q       <= shift_q[0];
            bit_idx_q  <= 3'd0;
            baud_cnt_q <= div_eff - 16'd1;
            state_q    <= S_DATA;
          end else begin
            baud_cnt_q <= baud_cnt_q - 16'd1;
          end
        end
        S_DATA: begin
          if (!bit_end) begin
            baud_cnt_q <= baud_cnt_q - 16'd1;
          end else if (bit_idx_q != 3'd7) begin
            bit_idx_q  <= bit_idx_q + 3'd1;
            shift_q    <= shift_q >> 1;
            tx_q       <= shift_q[1];
            baud_cnt_q <= div_eff - 16'd1;
          end else begin
`ifdef UART_TX_PARITY_EN
            tx_q       <= par_bit_q;
            baud_cnt_q <= div_eff - 16'd1;
            state_q    <= S_PARITY;
`else
            tx_q <= 1'b1;
            if (div_eff == 16'd1) begin
              state_q <= S_IDLE;
            end else begin
              baud_cnt_q <= div_eff - 16'd2;
              state_q    <= S_STOP;
            end
`endif
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (!bit_end) begin
            baud_cnt_q <= baud_cnt_q - 16'd1;
          end else begin
            tx_q <= 1'b1;
            if (div_eff == 16'd1) begin
              state_q <= S_IDLE;
            end else begin
              baud_cnt_q <= div_eff - 16'd2;
              state_q    <= S_STOP;
            end
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            state_q <= S_IDLE;
          end else begin
            baud_cnt_q <= baud_cnt_q - 16'd1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_wb.sv
// Scoreboard bench for uart_tx_wb: a frame-level reference model predicts bus read data,
// the serial line and the interrupt; a negedge monitor compares them with the DUT.
`timescale 1ns/1ps
module tb_uart_tx_wb;
  localparam int          DEPTH   = 16;
  localparam logic [15:0] RST_DIV = 16'd104;
`ifdef UART_TX_PARITY_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [31:0] wb_addr = 32'd0, wb_wdata = 32'd0;
  logic [3:0]  wb_sel = 4'd0;
  logic        wb_ack, wb_stall, uart_tx, irq;
  logic [31:0] wb_rdata;

  always #5 clk = ~clk;

  uart_tx_wb dut (
    .i_clk(clk), .i_rst(rst),
    .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .i_wb_we(wb_we),
    .i_wb_addr(wb_addr), .i_wb_data(wb_wdata), .i_wb_sel(wb_sel),
    .o_wb_ack(wb_ack), .o_wb_stall(wb_stall), .o_wb_data(wb_rdata),
    .o_uart_tx(uart_tx), .o_irq(irq)
  );

  typedef struct {
    int         start;
    int         d;
    logic [7:0] b;
    logic       par;
  } frame_t;

  // reference model state; "edge_n" numbers rising edges, cycle k follows edge k
  frame_t      frames[$];
  logic [7:0]  mq[$];
  logic [31:0] sb[$];
  int          idle_from = 0;
  int          edge_n = 0;
  logic        m_ovf = 1'b0;
  logic        m_odd = 1'b0;
  logic [15:0] m_div = RST_DIV;
  int          vectors = 0;
  int          misc = 0;

  function automatic int deff();
    return (m_div == 16'd0) ? 1 : int'(m_div);
  endfunction

  function automatic logic parity_bit(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
    return (^b) ^ m_odd;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic busy_at(int k);
    if (frames.size() == 0) return 1'b0;
    return (k >= frames[$].start) && (k <= frames[$].start + FL * frames[$].d - 2);
  endfunction

  function automatic logic line_at(int k);
    for (int i = frames.size() - 1; i >= 0; i--) begin
      if (k >= frames[i].start) begin
        int pos;
        if (k >= frames[i].start + FL * frames[i].d) return 1'b1;
        pos = (k - frames[i].start) / frames[i].d;
        if (pos == 0) return 1'b0;
        if (pos <= 8) return frames[i].b[pos-1];
        if (FL == 11 && pos == 9) return frames[i].par;
        return 1'b1;
      end
    end
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_status(int k);
    logic [31:0] st;
    st       = 32'd0;
    st[0]    = (mq.size() == DEPTH);
    st[1]    = (mq.size() == 0);
    st[2]    = busy_at(k);
    st[3]    = m_ovf;
`ifdef UART_TX_PARITY_EN
    st[4]    = m_odd;
`endif
    st[15:8] = 8'(mq.size());
    return st;
  endfunction

  task automatic model_reset();
    frames.delete();
    mq.delete();
    idle_from = 0;
    m_ovf     = 1'b0;
    m_odd     = 1'b0;
    m_div     = RST_DIV;
  endtask

  // one clock: optional single-beat request, then the model advances over the edge
  task automatic tick(input logic req, input logic we, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] sel);
    logic [31:0] exp;
    logic        full;
    logic [7:0]  b;
    int          d;
    exp = 32'd0;
    if (req && !we) begin
      case (addr[3:2])
        2'd1:    exp = exp_status(edge_n);
        2'd2:    exp = {16'd0, m_div};
        default: exp = 32'd0;
      endcase
    end
    wb_cyc = req; wb_stb = req; wb_we = we; wb_addr = addr; wb_wdata = data; wb_sel = sel;
    @(posedge clk);
    edge_n++;
    full = (mq.size() == DEPTH);
    if (mq.size() > 0 && edge_n >= idle_from) begin
      b = mq.pop_front();
      d = deff();
      frames.push_back('{edge_n, d, b, parity_bit(b)});
      if (frames.size() > 4) void'(frames.pop_front());
      idle_from = edge_n + FL * d;
    end
    if (req) sb.push_back(exp);
    if (req && we) begin
      case (addr[3:2])
        2'd0: if (sel[0]) begin
          if (full) m_ovf = 1'b1;
          else mq.push_back(data[7:0]);
        end
        2'd1: if (sel[0]) begin
          if (data[3]) m_ovf = 1'b0;
`ifdef UART_TX_PARITY_EN
          m_odd = data[4];
`endif
        end
        2'd2: begin
          if (sel[0]) m_div[7:0] = data[7:0];
          if (sel[1]) m_div[15:8] = data[15:8];
        end
        default: ;
      endcase
    end
    #1;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
    tick(1'b1, 1'b1, addr, data, sel);
  endtask

  task automatic rd(input logic [31:0] addr);
    tick(1'b1, 1'b0, addr, $urandom, 4'($urandom_range(0, 15)));
  endtask

  function automatic logic [31:0] addr_of(input logic [1:0] r);
    return ($urandom & 32'hFFFF_FFF3) | {28'd0, r, 2'b00};
  endfunction

  task automatic drain();
    int n;
    n = 0;
    while ((mq.size() != 0 || edge_n < idle_from) && n < 20000) begin
      idle();
      n++;
    end
    if (n >= 20000) begin
      vectors++; misc++;
      $display("FAIL drain: model still busy after %0d cycles, required idle", n);
    end
  endtask

  // monitor: bus response, serial line and interrupt, sampled mid-cycle
  always @(negedge clk) begin
    logic [31:0] e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      if (wb_ack !== 1'b1 || wb_rdata !== e) begin
        misc++;
        $display("FAIL wb_resp edge %0d: ack=%b data=%h, required ack=1 data=%h", edge_n, wb_ack, wb_rdata, e);
      end
    end else begin
      vectors++;
      if (wb_ack !== 1'b0 || wb_rdata !== 32'd0 || wb_stall !== 1'b0) begin
        misc++;
        $display("FAIL wb_idle edge %0d: ack=%b data=%h stall=%b, required 0/0/0", edge_n, wb_ack, wb_rdata, wb_stall);
      end
    end
    vectors++;
    if (uart_tx !== line_at(edge_n)) begin
      misc++;
      $display("FAIL uart_line cycle %0d: got %b, required %b", edge_n, uart_tx, line_at(edge_n));
    end
    vectors++;
    if (irq !== ((mq.size() == 0 && !busy_at(edge_n)) || m_ovf)) begin
      misc++;
      $display("FAIL irq cycle %0d: got %b, required %b", edge_n, irq, (mq.size() == 0 && !busy_at(edge_n)) || m_ovf);
    end
  end

  initial begin
    int s;
    logic [3:0] sels[4];
    sels = '{4'h1, 4'h3, 4'hF, 4'h0};
    model_reset();
    rst = 1'b1;
    repeat (3) idle();
    rst = 1'b0;

    // reset state
    rd(32'h4);
    rd(32'h8);

    // single frame at DIV=4, with read-after-write on STATUS
    wr(32'h8, 32'd4, 4'hF);
    wr(32'h0, 32'hA5, 4'hF);
    rd(32'h4);
    repeat (10) idle();
    rd(32'h4);
    drain();
    rd(32'h4);

    // overflow at DIV=2
    wr(32'h8, 32'd2, 4'hF);
    for (int i = 0; i < 18; i++) wr(32'h0, $urandom, 4'hF);
    rd(32'h4);
    wr(32'h4, 32'h8, 4'hF);
    rd(32'h4);
    drain();

    // back-to-back frames at DIV=1
    wr(32'h8, 32'd1, 4'h1);
    for (int i = 0; i < 3; i++) wr(32'h0, $urandom, 4'hF);
    drain();
    rd(32'h4);

`ifdef UART_TX_PARITY_EN
    wr(32'h4, 32'h0, 4'hF);
    wr(32'h8, 32'd4, 4'hF);
    wr(32'h0, 32'h07, 4'hF);
    drain();
    wr(32'h4, 32'h10, 4'hF);
    rd(32'h4);
    wr(32'h0, 32'h07, 4'hF);
    drain();
    wr(32'h4, 32'h0, 4'hF);
`endif

    // randomised traffic
    for (int it = 0; it < 60; it++) begin
      int r;
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3, 4: begin
          int k;
          k = $urandom_range(1, 4);
          for (int j = 0; j < k; j++)
            wr(addr_of(2'd0), $urandom, ($urandom_range(0, 3) == 0) ? 4'b1110 : (4'($urandom_range(0, 15)) | 4'b0001));
        end
        5: rd(addr_of(2'($urandom_range(0, 3))));
        6: repeat ($urandom_range(0, 30)) idle();
        7: begin
          drain();
          wr(addr_of(2'd2), ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 5)), sels[$urandom_range(0, 3)]);
          rd(addr_of(2'd2));
        end
        8: wr(addr_of(2'd1), $urandom, 4'($urandom_range(0, 15)));
        default: wr(addr_of(2'd3), $urandom, 4'hF);
      endcase
    end
    drain();
    rd(32'h4);

    // asynchronous reset during data bit 3
    wr(32'h8, 32'd4, 4'hF);
    wr(32'h0, 32'h00, 4'hF);
    idle();
    s = (frames.size() > 0) ? frames[$].start : edge_n;
    for (int n = 0; n < 100 && edge_n < s + 17; n++) idle();
    rst = 1'b1;
    #1;
    vectors++;
    if (uart_tx !== 1'b1) begin
      misc++;
      $display("FAIL reset_line: got %b, required 1", uart_tx);
    end
    model_reset();
    idle();
    rst = 1'b0;
    rd(32'h4);
    rd(32'h8);
    repeat (3) idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end
endmodule
